// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoder E/M/W bundles through ID/EX, EX/MEM and MEM/WB,
// tracks the destination register, and resolves load-use stalls and control-hazard flushes.
module ctrl_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_ctrl_e,
   input  logic [2:0]       id_ctrl_m,
   input  logic [1:0]       id_ctrl_w,
   input  logic             id_jump,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             ex_zero,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             ex_alu_src,
   output logic             ex_reg_dst,
   output logic             ex_jr,
   output logic [1:0]       ex_alu_op,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic             mem_branch_taken,
   output logic             mem_mem_write,
   output logic             mem_mem_read,
   output logic [4:0]       mem_wreg,
   output logic             wb_mem_to_reg,
   output logic             wb_reg_write,
   output logic [4:0]       wb_wreg,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       idex_branch;
   logic       idex_mem_write;
   logic       idex_mem_read;
   logic       idex_mem_to_reg;
   logic       idex_reg_write;
   logic [4:0] idex_rd;
   logic       exmem_mem_to_reg;
   logic       exmem_reg_write;

   logic       load_use;
   logic       stall;
   logic       idex_bubble;
   logic       exmem_bubble;

   // Hazard resolution: taken branch > JR in EX > load-use > jump in ID
   always_comb begin
      load_use     = idex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
      stall        = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      if (mem_branch_taken) begin
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else if (ex_jr) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         stall       = 1'b1;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (id_jump) begin
         ifid_flush = 1'b1;
      end else begin
         ifid_flush = 1'b0;
      end
   end

   // ID/EX register; write-enabling bits only load as 1 when the input is a clean 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst || idex_bubble) begin
         ex_alu_src      <= 1'b0;
         ex_reg_dst      <= 1'b0;
         ex_jr           <= 1'b0;
         ex_alu_op       <= 2'b00;
         idex_branch     <= 1'b0;
         idex_mem_write  <= 1'b0;
         idex_mem_read   <= 1'b0;
         idex_mem_to_reg <= 1'b0;
         idex_reg_write  <= 1'b0;
         ex_rs           <= 5'd0;
         ex_rt           <= 5'd0;
         idex_rd         <= 5'd0;
      end else begin
         ex_alu_src      <= id_ctrl_e[4];
         ex_reg_dst      <= id_ctrl_e[3];
         ex_jr           <= (id_ctrl_e[2] === 1'b1);
         ex_alu_op       <= id_ctrl_e[1:0];
         idex_branch     <= (id_ctrl_m[2] === 1'b1);
         idex_mem_write  <= (id_ctrl_m[1] === 1'b1);
         idex_mem_read   <= (id_ctrl_m[0] === 1'b1);
         idex_mem_to_reg <= id_ctrl_w[1];
         idex_reg_write  <= (id_ctrl_w[0] === 1'b1);
         ex_rs           <= id_rs;
         ex_rt           <= id_rt;
         idex_rd         <= id_rd;
      end
   end

   // EX/MEM register; branch outcome is resolved here from the EX zero flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst || exmem_bubble) begin
         mem_branch_taken <= 1'b0;
         mem_mem_write    <= 1'b0;
         mem_mem_read     <= 1'b0;
         exmem_mem_to_reg <= 1'b0;
         exmem_reg_write  <= 1'b0;
         mem_wreg         <= 5'd0;
      end else begin
         mem_branch_taken <= idex_branch & ex_zero;
         mem_mem_write    <= idex_mem_write;
         mem_mem_read     <= idex_mem_read;
         exmem_mem_to_reg <= idex_mem_to_reg;
         exmem_reg_write  <= idex_reg_write;
         mem_wreg         <= ex_reg_dst ? idex_rd : ex_rt;
      end
   end

   // MEM/WB register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_mem_to_reg <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_wreg       <= 5'd0;
      end else begin
         wb_mem_to_reg <= exmem_mem_to_reg;
         wb_reg_write  <= exmem_reg_write;
         wb_wreg       <= mem_wreg;
      end
   end

   // Saturating stall and flush event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= {CNT_W{1'b0}};
         flush_count <= {CNT_W{1'b0}};
      end else begin
         if (stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
         end else begin
            stall_count <= stall_count;
         end
         if (ifid_flush && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_ONE;
         end else begin
            flush_count <= flush_count;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe; each task drives one scenario and checks inline.
module tb_ctrl_pipe;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_ctrl_e;
   logic [2:0]       id_ctrl_m;
   logic [1:0]       id_ctrl_w;
   logic             id_jump;
   logic [4:0]       id_rs, id_rt, id_rd;
   logic             ex_zero;
   logic             pc_write, ifid_write, ifid_flush;
   logic             ex_alu_src, ex_reg_dst, ex_jr;
   logic [1:0]       ex_alu_op;
   logic [4:0]       ex_rs, ex_rt;
   logic             mem_branch_taken, mem_mem_write, mem_mem_read;
   logic [4:0]       mem_wreg;
   logic             wb_mem_to_reg, wb_reg_write;
   logic [4:0]       wb_wreg;
   logic [CNT_W-1:0] stall_count, flush_count;

   int tests = 0;
   int fails = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   ctrl_pipe #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_ctrl_e(id_ctrl_e), .id_ctrl_m(id_ctrl_m), .id_ctrl_w(id_ctrl_w),
      .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_jr(ex_jr), .ex_alu_op(ex_alu_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
      .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read), .mem_wreg(mem_wreg),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] e, input logic [2:0] m, input logic [1:0] w,
                        input logic j, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_ctrl_e = e; id_ctrl_m = m; id_ctrl_w = w; id_jump = j;
      id_rs = rs; id_rt = rt; id_rd = rd;
      #1;
   endtask

   task automatic drain;
      drive(5'b00000, 3'b000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
      repeat (3) tick;
   endtask

   task automatic test_reset;
      rst = 1'b1; ex_zero = 1'b0;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd1, 5'd2, 5'd5);
      @(negedge clk); rst = 1'b0;
      repeat (3) tick;
      tests++; if (wb_reg_write !== 1'b1) begin fails++; $display("FAIL prefill_wb_reg_write got %b want 1", wb_reg_write); end
      rst = 1'b1; #1;
      tests++; if ({ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt} !== 15'd0) begin fails++; $display("FAIL reset_ex got %h want 0", {ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt}); end
      tests++; if ({mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg} !== 8'd0) begin fails++; $display("FAIL reset_mem got %h want 0", {mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg}); end
      tests++; if ({wb_mem_to_reg, wb_reg_write, wb_wreg} !== 7'd0) begin fails++; $display("FAIL reset_wb got %h want 0", {wb_mem_to_reg, wb_reg_write, wb_wreg}); end
      tests++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin fails++; $display("FAIL reset_hazard got %b want 110", {pc_write, ifid_write, ifid_flush}); end
      drive(5'b00000, 3'b000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk); rst = 1'b0;
      tick;
      tests++; if ({stall_count, flush_count} !== 16'd0) begin fails++; $display("FAIL reset_counters got %h want 0", {stall_count, flush_count}); end
   endtask

   task automatic test_rtype;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd1, 5'd2, 5'd5);
      tick;
      tests++; if ({ex_alu_src, ex_reg_dst, ex_alu_op} !== 4'b0110) begin fails++; $display("FAIL rtype_ex got %b want 0110", {ex_alu_src, ex_reg_dst, ex_alu_op}); end
      drive(5'b00000, 3'b000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
      tick;
      tests++; if (mem_wreg !== 5'd5) begin fails++; $display("FAIL rtype_mem_wreg got %0d want 5", mem_wreg); end
      tick;
      tests++; if ({wb_reg_write, wb_mem_to_reg, wb_wreg} !== {1'b1, 1'b1, 5'd5}) begin fails++; $display("FAIL rtype_wb got %b%b/%0d want 11/5", wb_reg_write, wb_mem_to_reg, wb_wreg); end
      drain;
   endtask

   task automatic test_load_use;
      drive(5'b10000, 3'b001, 2'b01, 1'b0, 5'd9, 5'd8, 5'd0);
      tick;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd8, 5'd3, 5'd10);
      tests++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin fails++; $display("FAIL lu_hazard got %b want 000", {pc_write, ifid_write, ifid_flush}); end
      tick; exp_stall++;
      tests++; if ({ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt} !== 15'd0) begin fails++; $display("FAIL lu_bubble got %h want 0", {ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt}); end
      tests++; if (stall_count !== exp_stall[CNT_W-1:0]) begin fails++; $display("FAIL lu_stall_count got %0d want %0d", stall_count, exp_stall); end
      tests++; if ({mem_mem_read, mem_wreg, pc_write} !== {1'b1, 5'd8, 1'b1}) begin fails++; $display("FAIL lu_mem got %b/%0d/%b want 1/8/1", mem_mem_read, mem_wreg, pc_write); end
      tick;
      tests++; if ({ex_rs, ex_reg_dst} !== {5'd8, 1'b1}) begin fails++; $display("FAIL lu_resume got %0d/%b want 8/1", ex_rs, ex_reg_dst); end
      drain;
      drive(5'b10000, 3'b001, 2'b01, 1'b0, 5'd9, 5'd0, 5'd0);
      tick;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd0, 5'd3, 5'd10);
      tests++; if ({pc_write, ifid_write} !== 2'b11) begin fails++; $display("FAIL lu_r0_hazard got %b want 11", {pc_write, ifid_write}); end
      tick;
      tests++; if ({ex_reg_dst, stall_count} !== {1'b1, exp_stall[CNT_W-1:0]}) begin fails++; $display("FAIL lu_r0_pass got %b/%0d want 1/%0d", ex_reg_dst, stall_count, exp_stall); end
      drain;
   endtask

   task automatic test_branch;
      drive(5'b00001, 3'b100, 2'b00, 1'b0, 5'd1, 5'd2, 5'd0);
      tick;
      ex_zero = 1'b1;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd4, 5'd5, 5'd7);
      tick;
      ex_zero = 1'b0;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd1, 5'd2, 5'd9);
      tests++; if ({mem_branch_taken, ifid_flush, pc_write, ifid_write} !== 4'b1111) begin fails++; $display("FAIL br_taken got %b want 1111", {mem_branch_taken, ifid_flush, pc_write, ifid_write}); end
      tick; exp_flush++;
      tests++; if ({ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt} !== 15'd0) begin fails++; $display("FAIL br_ex_bubble got %h want 0", {ex_alu_src, ex_reg_dst, ex_jr, ex_alu_op, ex_rs, ex_rt}); end
      tests++; if ({mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg} !== 8'd0) begin fails++; $display("FAIL br_mem_bubble got %h want 0", {mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg}); end
      tests++; if (flush_count !== exp_flush[CNT_W-1:0]) begin fails++; $display("FAIL br_flush_count got %0d want %0d", flush_count, exp_flush); end
      drain;
      drive(5'b00001, 3'b100, 2'b00, 1'b0, 5'd1, 5'd2, 5'd0);
      tick;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd4, 5'd5, 5'd7);
      tick;
      tests++; if ({mem_branch_taken, ifid_flush} !== 2'b00) begin fails++; $display("FAIL br_not_taken got %b want 00", {mem_branch_taken, ifid_flush}); end
      tick;
      tests++; if ({ex_reg_dst, flush_count} !== {1'b1, exp_flush[CNT_W-1:0]}) begin fails++; $display("FAIL br_nt_flow got %b/%0d want 1/%0d", ex_reg_dst, flush_count, exp_flush); end
      drain;
   endtask

   task automatic test_jr_load_use;
      drive(5'b00100, 3'b001, 2'b00, 1'b0, 5'd31, 5'd8, 5'd0);
      tick;
      drive(5'b01010, 3'b000, 2'b11, 1'b0, 5'd8, 5'd3, 5'd10);
      tests++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin fails++; $display("FAIL jr_lu_hazard got %b want 111", {ifid_flush, pc_write, ifid_write}); end
      tick; exp_flush++;
      tests++; if ({stall_count, flush_count} !== {exp_stall[CNT_W-1:0], exp_flush[CNT_W-1:0]}) begin fails++; $display("FAIL jr_lu_counts got %0d/%0d want %0d/%0d", stall_count, flush_count, exp_stall, exp_flush); end
      tests++; if ({ex_jr, ex_rs, ex_rt, mem_mem_read, mem_wreg} !== {1'b0, 5'd0, 5'd0, 1'b1, 5'd8}) begin fails++; $display("FAIL jr_lu_pipe got %b/%0d/%0d/%b/%0d want 0/0/0/1/8", ex_jr, ex_rs, ex_rt, mem_mem_read, mem_wreg); end
      drain;
   endtask

   task automatic test_jump;
      drive(5'b00000, 3'b000, 2'b00, 1'b1, 5'd3, 5'd4, 5'd0);
      tests++; if ({ifid_flush, pc_write} !== 2'b11) begin fails++; $display("FAIL j_hazard got %b want 11", {ifid_flush, pc_write}); end
      tick; exp_flush++;
      tests++; if ({ex_rs, flush_count} !== {5'd3, exp_flush[CNT_W-1:0]}) begin fails++; $display("FAIL j_enter got %0d/%0d want 3/%0d", ex_rs, flush_count, exp_flush); end
      drain;
      drive(5'b10000, 3'b001, 2'b01, 1'b0, 5'd9, 5'd8, 5'd0);
      tick;
      drive(5'b00000, 3'b000, 2'b00, 1'b1, 5'd8, 5'd0, 5'd0);
      tests++; if ({ifid_flush, pc_write} !== 2'b00) begin fails++; $display("FAIL j_lu_priority got %b want 00", {ifid_flush, pc_write}); end
      tick; exp_stall++;
      tests++; if ({ifid_flush, stall_count} !== {1'b1, exp_stall[CNT_W-1:0]}) begin fails++; $display("FAIL j_after_stall got %b/%0d want 1/%0d", ifid_flush, stall_count, exp_stall); end
      tick; exp_flush++;
      drain;
   endtask

   task automatic test_sanitise;
      drive(5'b01z00, 3'bxzx, 2'b1x, 1'b0, 5'd0, 5'd0, 5'd6);
      tick;
      ex_zero = 1'b1;
      tests++; if (ex_jr !== 1'b0) begin fails++; $display("FAIL san_jr got %b want 0", ex_jr); end
      drive(5'b00000, 3'b000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
      tick;
      ex_zero = 1'b0;
      tests++; if ({mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg} !== {3'b000, 5'd6}) begin fails++; $display("FAIL san_mem got %b%b%b/%0d want 000/6", mem_branch_taken, mem_mem_write, mem_mem_read, mem_wreg); end
      tick;
      tests++; if ({wb_reg_write, wb_mem_to_reg, wb_wreg} !== {1'b0, 1'b1, 5'd6}) begin fails++; $display("FAIL san_wb got %b%b/%0d want 01/6", wb_reg_write, wb_mem_to_reg, wb_wreg); end
      drain;
   endtask

   task automatic test_saturation;
      drive(5'b10000, 3'b001, 2'b01, 1'b0, 5'd8, 5'd8, 5'd0);
      repeat (600) tick;
      tests++; if (stall_count !== {CNT_W{1'b1}}) begin fails++; $display("FAIL sat_stall got %0d want %0d", stall_count, (1 << CNT_W) - 1); end
      tests++; if (flush_count !== exp_flush[CNT_W-1:0]) begin fails++; $display("FAIL sat_flush got %0d want %0d", flush_count, exp_flush); end
      rst = 1'b1; #1;
      tests++; if ({stall_count, flush_count, pc_write} !== {16'd0, 1'b1}) begin fails++; $display("FAIL sat_reset got %h/%b want 0/1", {stall_count, flush_count}, pc_write); end
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      test_reset;
      test_rtype;
      test_load_use;
      test_branch;
      test_jr_load_use;
      test_jump;
      test_sanitise;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
